dmux8way16_buf: RTL and testbench

- Write-side counterpart of the 8-way 16-bit selector: steers one 16-bit input word to one of 8 output lanes chosen by a 3-bit select.
- Each lane has a one-entry holding register with a valid/ready handshake, so producer and consumers are decoupled.
- Sits between the datapath's result bus and the 8 per-destination consumers (register-bank write ports, I/O sinks).
- Also keeps an occupancy count and a wrapping count of accepted words for debug and status.

---
 rtl/dmux8way16_buf.sv | 122 ++++++++++++
 tb/tb_dmux8way16_buf.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux8way16_buf.sv
// 8-way write-side demultiplexer: steers one input word into one of eight
// single-entry lane buffers, each with its own valid/ready handshake.
module dmux8way16_buf #(
    parameter int WIDTH  = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [WIDTH-1:0] out8,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [3:0]       occupancy,
    output logic [15:0]      accept_cnt
);

    logic [WIDTH-1:0] r_data [8];
    logic [7:0]       r_valid;
    logic [3:0]       r_occ;
    logic [15:0]      r_cnt;

    logic             w_in_ready;
    logic             w_fire;
    logic [7:0]       w_drain;
    logic [7:0]       w_fill;
    logic [7:0]       w_valid_nxt;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'd0, v[i]};
        end
        return sum;
    endfunction

    // Input-side handshake: only the selected lane's state matters.
    always_comb begin
        w_in_ready = 1'b0;
        if (flush) begin
            w_in_ready = 1'b0;
        end else if (BYPASS) begin
            w_in_ready = ~r_valid[in_sel] | out_ready[in_sel];
        end else begin
            w_in_ready = ~r_valid[in_sel];
        end
    end

    assign w_fire  = in_valid & w_in_ready;
    assign w_drain = r_valid & out_ready;

    // Fill mask and next-state valid vector; a fill wins over a same-lane drain.
    always_comb begin
        w_fill      = 8'd0;
        w_valid_nxt = 8'd0;
        if (w_fire) begin
            w_fill = 8'd1 << in_sel;
        end else begin
            w_fill = 8'd0;
        end
        if (flush) begin
            w_valid_nxt = 8'd0;
        end else begin
            w_valid_nxt = (r_valid & ~w_drain) | w_fill;
        end
    end

    // Lane data registers load only on a fill; drains leave data in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_data[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_fill[i]) begin
                    r_data[i] <= in_data;
                end
            end
        end
    end

    // Valid flags, occupancy and the wrapping accept counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 8'd0;
            r_occ   <= 4'd0;
            r_cnt   <= 16'd0;
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= popcount8(w_valid_nxt);
            if (w_fire) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_valid;
    assign occupancy  = r_occ;
    assign accept_cnt = r_cnt;
    assign out1 = r_data[0];
    assign out2 = r_data[1];
    assign out3 = r_data[2];
    assign out4 = r_data[3];
    assign out5 = r_data[4];
    assign out6 = r_data[5];
    assign out7 = r_data[6];
    assign out8 = r_data[7];

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Self-checking bench for dmux8way16_buf: a BYPASS=1 and a BYPASS=0 instance
// share stimulus; expected lane contents flow through a scoreboard queue.
module tb_dmux8way16_buf;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic [7:0]  out_ready;

    logic        in_ready_b, in_ready_n;
    logic [15:0] ob1, ob2, ob3, ob4, ob5, ob6, ob7, ob8;
    logic [15:0] on1, on2, on3, on4, on5, on6, on7, on8;
    logic [7:0]  ov_b, ov_n;
    logic [3:0]  occ_b, occ_n;
    logic [15:0] cnt_b, cnt_n;
    logic [15:0] w_ob [8];
    logic [15:0] w_on [8];

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;

    typedef struct {
        logic [2:0]  lane;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
        logic [7:0]  exp_valid;
        logic [3:0]  exp_occ;
    } vec_t;
    vec_t vecs [8];

    dmux8way16_buf #(.WIDTH(16), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_data(in_data), .in_sel(in_sel),
        .out1(ob1), .out2(ob2), .out3(ob3), .out4(ob4),
        .out5(ob5), .out6(ob6), .out7(ob7), .out8(ob8),
        .out_valid(ov_b), .out_ready(out_ready), .occupancy(occ_b),
        .accept_cnt(cnt_b)
    );

    dmux8way16_buf #(.WIDTH(16), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_n), .in_data(in_data), .in_sel(in_sel),
        .out1(on1), .out2(on2), .out3(on3), .out4(on4),
        .out5(on5), .out6(on6), .out7(on7), .out8(on8),
        .out_valid(ov_n), .out_ready(out_ready), .occupancy(occ_n),
        .accept_cnt(cnt_n)
    );

    assign w_ob[0] = ob1; assign w_ob[1] = ob2; assign w_ob[2] = ob3; assign w_ob[3] = ob4;
    assign w_ob[4] = ob5; assign w_ob[5] = ob6; assign w_ob[6] = ob7; assign w_ob[7] = ob8;
    assign w_on[0] = on1; assign w_on[1] = on2; assign w_on[2] = on3; assign w_on[3] = on4;
    assign w_on[4] = on5; assign w_on[5] = on6; assign w_on[6] = on7; assign w_on[7] = on8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        in_sel    = 3'd0;
        out_ready = 8'd0;
        sb.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single accepted write with no drains; expectation goes through the scoreboard.
    task automatic put(input logic [2:0] sel, input logic [15:0] data);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        #1;
        chk("put_in_ready", {31'd0, in_ready_b}, 32'd1);
        sb.push_back('{lane: sel, data: data});
        m_cnt++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = sb.pop_front();
        chk("put_lane_data", {16'd0, w_ob[e.lane]}, {16'd0, e.data});
        chk("put_lane_valid", {31'd0, ov_b[e.lane]}, 32'd1);
        chk("put_accept_cnt", {16'd0, cnt_b}, m_cnt);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i].sel       = 3'(i);
            vecs[i].data      = 16'h1000 + 16'(i);
            vecs[i].exp_valid = 8'((16'd1 << (i + 1)) - 16'd1);
            vecs[i].exp_occ   = 4'(i + 1);
        end

        // Reset state and single write to lane 5.
        do_reset();
        #1;
        chk("rst_out_valid", {24'd0, ov_b}, 32'd0);
        chk("rst_occupancy", {28'd0, occ_b}, 32'd0);
        chk("rst_accept_cnt", {16'd0, cnt_b}, 32'd0);
        chk("rst_out6", {16'd0, ob6}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_b}, 32'd1);
        put(3'd5, 16'hBEEF);
        chk("t1_out6", {16'd0, ob6}, 32'h0000BEEF);
        chk("t1_out_valid", {24'd0, ov_b}, 32'h20);
        chk("t1_occupancy", {28'd0, occ_b}, 32'd1);

        // Fill all eight lanes from the vector table, then stall.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            put(vecs[i].sel, vecs[i].data);
            chk("t2_out_valid", {24'd0, ov_b}, {24'd0, vecs[i].exp_valid});
            chk("t2_occupancy", {28'd0, occ_b}, {28'd0, vecs[i].exp_occ});
        end
        for (int i = 0; i < 8; i++) begin
            in_sel = 3'(i);
            #1;
            chk("t2_full_in_ready", {31'd0, in_ready_b}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 3'd3;
        in_data  = 16'hDEAD;
        @(posedge clk);
        #1;
        chk("t2_stall_out4", {16'd0, ob4}, 32'h1003);
        chk("t2_stall_cnt", {16'd0, cnt_b}, 32'd8);
        chk("t2_stall_occ", {28'd0, occ_b}, 32'd8);
        in_valid = 1'b0;

        // Same-cycle drain and refill of lane 2, bypass vs no bypass.
        do_reset();
        put(3'd2, 16'h00AA);
        @(negedge clk);
        out_ready = 8'h04;
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        in_data   = 16'h00BB;
        #1;
        chk("t3_byp_in_ready", {31'd0, in_ready_b}, 32'd1);
        chk("t3_nobyp_in_ready", {31'd0, in_ready_n}, 32'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 8'd0;
        chk("t3_byp_out3", {16'd0, ob3}, 32'h00BB);
        chk("t3_byp_valid", {24'd0, ov_b}, 32'h04);
        chk("t3_byp_cnt", {16'd0, cnt_b}, 32'd2);
        chk("t3_nobyp_out3", {16'd0, on3}, 32'h00AA);
        chk("t3_nobyp_valid", {24'd0, ov_n}, 32'h00);
        chk("t3_nobyp_cnt", {16'd0, cnt_n}, 32'd1);
        chk("t3_nobyp_occ", {28'd0, occ_n}, 32'd0);

        // Independent multi-lane drain alongside a write to another lane.
        do_reset();
        put(3'd1, 16'h0111);
        put(3'd4, 16'h0444);
        put(3'd7, 16'h0777);
        @(negedge clk);
        out_ready = 8'b1001_0010;
        in_valid  = 1'b1;
        in_sel    = 3'd0;
        in_data   = 16'h5555;
        #1;
        chk("t4_in_ready", {31'd0, in_ready_b}, 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 8'd0;
        chk("t4_out_valid", {24'd0, ov_b}, 32'h01);
        chk("t4_occupancy", {28'd0, occ_b}, 32'd1);
        chk("t4_out1", {16'd0, ob1}, 32'h5555);
        chk("t4_out5_holds", {16'd0, ob5}, 32'h0444);

        // accept_cnt wrap: 65535 streamed writes with every lane draining.
        do_reset();
        out_ready = 8'hFF;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sel   = 3'(i % 8);
            in_data  = 16'(i);
        end
        @(posedge clk);
        #1;
        chk("t5_cnt_ffff", {16'd0, cnt_b}, 32'hFFFF);
        chk("t5_nobyp_cnt_ffff", {16'd0, cnt_n}, 32'hFFFF);
        @(negedge clk);
        in_sel = 3'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t5_cnt_wrap", {16'd0, cnt_b}, 32'h0000);
        @(negedge clk);
        out_ready = 8'd0;

        // Flush with four lanes valid, X tolerance when idle, then async reset mid-write.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(3'(2 * i), 16'h2000 + 16'(2 * i));
        end
        chk("t6_pre_flush_occ", {28'd0, occ_b}, 32'd4);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 3'd1;
        in_data  = 16'h9999;
        #1;
        chk("t6_flush_in_ready", {31'd0, in_ready_b}, 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t6_flush_valid", {24'd0, ov_b}, 32'd0);
        chk("t6_flush_occ", {28'd0, occ_b}, 32'd0);
        chk("t6_flush_out1", {16'd0, ob1}, 32'h2000);
        chk("t6_flush_out5", {16'd0, ob5}, 32'h2004);
        chk("t6_flush_out2", {16'd0, ob2}, 32'h0000);
        chk("t6_flush_cnt", {16'd0, cnt_b}, 32'd4);
        @(negedge clk);
        in_sel    = 3'bxxx;
        in_data   = 16'hxxxx;
        out_ready = 8'hxx;
        @(posedge clk);
        #1;
        chk("t6_idle_x_valid", {24'd0, ov_b}, 32'd0);
        chk("t6_idle_x_cnt", {16'd0, cnt_b}, 32'd4);
        @(negedge clk);
        out_ready = 8'd0;
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        in_data   = 16'h7777;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_out1", {16'd0, ob1}, 32'd0);
        chk("t6_arst_out5", {16'd0, ob5}, 32'd0);
        chk("t6_arst_valid", {24'd0, ov_b}, 32'd0);
        chk("t6_arst_occ", {28'd0, occ_b}, 32'd0);
        chk("t6_arst_cnt", {16'd0, cnt_b}, 32'd0);
        @(posedge clk);
        #1;
        chk("t6_arst_hold_out4", {16'd0, ob4}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_post_rst_valid", {24'd0, ov_b}, 32'd0);
        chk("t6_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
